// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg -- shared defines for the instruction queue.
//   INST_ADDR_W / INST_W : InstAddrBus / InstBus widths
//   NOP_ADDR / NOP_INST  : values driven on id_* when nothing is valid
//   DEFAULT_DEPTH        : default queue depth (power of two, >= 2)
package inst_queue_pkg;

  localparam int INST_ADDR_W   = 32;
  localparam int INST_W        = 32;
  localparam int ENTRY_W       = INST_ADDR_W + INST_W;
  localparam int DEFAULT_DEPTH = 4;

  localparam logic [INST_ADDR_W-1:0] NOP_ADDR = 32'h0000_0000;
  localparam logic [INST_W-1:0]      NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_mem.sv
// inst_queue_mem -- DEPTH x 64-bit register file holding {pc, inst} pairs.
//   clk   : clock
//   we    : write enable (synchronous write on rising edge)
//   waddr : write index
//   wdata : entry to store
//   raddr : read index (asynchronous read)
//   rdata : entry at raddr
// Contents are deliberately not reset; occupancy tracking lives in the parent.
module inst_queue_mem
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  iq_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output iq_entry_t        rdata
);

  iq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue.sv
// inst_queue -- circular instruction queue between fetch and decode.
//   clk, rst             : clock, synchronous active-high reset
//   if_valid/if_pc/if_inst/if_ready : fetch-side push handshake
//   flush                : drop everything queued and the incoming instruction
//   id_valid/id_pc/id_inst/id_ready : decode-side pop handshake (NOP when !id_valid)
//   count                : occupancy 0..DEPTH
// Optional macro INST_QUEUE_BYPASS_EN: when empty, the fetch instruction is
// forwarded combinationally to id_*; if decode takes it, it is never stored.
// Default build has no if_* -> id_* combinational path (one-cycle latency).
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid,
  input  logic [INST_ADDR_W-1:0]  if_pc,
  input  logic [INST_W-1:0]       if_inst,
  output logic                    if_ready,
  input  logic                    flush,
  output logic                    id_valid,
  output logic [INST_ADDR_W-1:0]  id_pc,
  output logic [INST_W-1:0]       id_inst,
  input  logic                    id_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic      empty, full;
  logic      push, pop;
  logic      mem_we, mem_re;
  logic      bypass;
  iq_entry_t rd_entry, wr_entry;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Full blocks pushes even if a pop frees a slot this cycle: keeps if_ready
  // independent of id_ready.
  assign if_ready = !rst && !full;

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass = !rst && empty && if_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign id_valid = !rst && (!empty || bypass);

  assign push = if_valid && if_ready && !flush;
  assign pop  = id_valid && id_ready && !flush;

  // A bypassed instruction consumed by decode this cycle is never stored;
  // pops only touch storage when there is something in it.
  assign mem_we = push && !(bypass && id_ready);
  assign mem_re = pop && !empty;

  assign wr_entry = '{pc: if_pc, inst: if_inst};

  inst_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointer overflow is the wrap DEPTH-1 -> 0.
      if (mem_we) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (mem_re) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({mem_we, mem_re})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    id_pc   = NOP_ADDR;
    id_inst = NOP_INST;
    if (id_valid) begin
      if (empty) begin
        id_pc   = if_pc;
        id_inst = if_inst;
      end else begin
        id_pc   = rd_entry.pc;
        id_inst = rd_entry.inst;
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  logic [31:0] mq[$];

  inst_queue #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .flush    (flush),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_ready (id_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_inst  = 32'hA000_0000 | pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    drive_if(1'b0, 32'h0);
    tick(); tick();
    // reset state
    chk("rst_count",    64'(count), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_id_pc",    64'(id_pc), 64'd0);
    chk("rst_id_inst",  64'(id_inst), 64'd0);
    rst = 1'b0; #1;
    chk("post_rst_if_ready", 64'(if_ready), 64'd1);

    // three pushes, decode stalled
    for (int i = 0; i < 3; i++) begin
      drive_if(1'b1, 32'(4 * i));
      tick();
    end
    drive_if(1'b0, 32'h0); #1;
    chk("p3_count",    64'(count), 64'd3);
    chk("p3_id_pc",    64'(id_pc), 64'h0);
    chk("p3_id_inst",  64'(id_inst), 64'hA000_0000);
    chk("p3_if_ready", 64'(if_ready), 64'd1);
    tick();
    chk("p3_hold_pc",  64'(id_pc), 64'h0);

    // fill, then an ignored 5th push
    drive_if(1'b1, 32'hC); tick();
    chk("full_count",    64'(count), 64'd4);
    chk("full_if_ready", 64'(if_ready), 64'd0);
    drive_if(1'b1, 32'h10); tick();
    chk("full_ign_count", 64'(count), 64'd4);
    drive_if(1'b0, 32'h0);
    id_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("pop_order", 64'(id_pc), 64'(4 * i));
      tick();
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", 64'(id_valid), 64'd0);
    chk("drain_pc",    64'(id_pc), 64'd0);

    // full + simultaneous push/pop: push rejected
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_if(1'b1, 32'(4 * i)); tick();
    end
    drive_if(1'b1, 32'h200); id_ready = 1'b1; #1;
    chk("fpp_if_ready", 64'(if_ready), 64'd0);
    tick();
    chk("fpp_count", 64'(count), 64'd3);
    chk("fpp_head",  64'(id_pc), 64'h4);
    drive_if(1'b0, 32'h0); tick();
    chk("c2_count", 64'(count), 64'd2);

    // steady push+pop at count 2 across pointer wraps
    mq = '{32'h8, 32'hC};
    for (int k = 0; k < 10; k++) begin
      chk("ss_count", 64'(count), 64'd2);
      chk("ss_head",  64'(id_pc), 64'(mq[0]));
      drive_if(1'b1, 32'h300 + 32'(4 * k));
      id_ready = 1'b1;
      tick();
      void'(mq.pop_front());
      mq.push_back(32'h300 + 32'(4 * k));
    end
    drive_if(1'b0, 32'h0); id_ready = 1'b0; #1;
    chk("ss_end_count", 64'(count), 64'd2);
    chk("ss_end_head",  64'(id_pc), 64'(mq[0]));

    // flush at count 3 with a concurrent fetch
    drive_if(1'b1, 32'h400); tick();
    chk("pre_flush_count", 64'(count), 64'd3);
    drive_if(1'b1, 32'h100); flush = 1'b1; tick();
    flush = 1'b0; drive_if(1'b0, 32'h0); #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(id_valid), 64'd0);
    chk("flush_pc",    64'(id_pc), 64'd0);
    id_ready = 1'b1; tick();
    chk("flush_no100_valid", 64'(id_valid), 64'd0);
    chk("flush_no100_count", 64'(count), 64'd0);

    // empty queue, fetch with decode ready
    drive_if(1'b1, 32'h20); id_ready = 1'b1; #1;
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_valid", 64'(id_valid), 64'd1);
    chk("byp_pc",    64'(id_pc), 64'h20);
    chk("byp_inst",  64'(id_inst), 64'hA000_0020);
    tick();
    drive_if(1'b0, 32'h0); #1;
    chk("byp_count", 64'(count), 64'd0);
    chk("byp_after_valid", 64'(id_valid), 64'd0);
`else
    chk("nobyp_valid0", 64'(id_valid), 64'd0);
    chk("nobyp_pc0",    64'(id_pc), 64'd0);
    tick();
    drive_if(1'b0, 32'h0); #1;
    chk("nobyp_count1", 64'(count), 64'd1);
    chk("nobyp_valid1", 64'(id_valid), 64'd1);
    chk("nobyp_pc1",    64'(id_pc), 64'h20);
    tick();
    chk("nobyp_count0", 64'(count), 64'd0);
`endif

    // reset mid-operation at count 2
    id_ready = 1'b0;
    drive_if(1'b1, 32'h500); tick();
    drive_if(1'b1, 32'h504); tick();
    drive_if(1'b0, 32'h0); #1;
    chk("mr_pre_count", 64'(count), 64'd2);
    rst = 1'b1; #1;
    chk("mr_if_ready_rst", 64'(if_ready), 64'd0);
    chk("mr_id_valid_rst", 64'(id_valid), 64'd0);
    tick();
    chk("mr_count", 64'(count), 64'd0);
    chk("mr_if_ready_hold", 64'(if_ready), 64'd0);
    rst = 1'b0; #1;
    chk("mr_if_ready_rel", 64'(if_ready), 64'd1);
    chk("mr_id_valid_rel", 64'(id_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
